// File: rtl/nios_system_mult_arbiter.sv
// nios_system_mult_arbiter: round-robin sharing of one pipelined
// 32-bit multiplier cell between two requesters, with tagged returns.
module nios_system_mult_arbiter #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_result0,
    output logic [31:0] rsp_result1,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_result
);

    localparam int STAGES = MUL_LATENCY + 1;

    logic [1:0]        busy;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        rsp_hs;
    logic              last;
    logic [STAGES-1:0] tag_vld;
    logic [STAGES-1:0] tag_id;
    logic              fin_vld;
    logic              fin_id;

    assign elig      = req_valid & ~busy;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign fin_vld   = tag_vld[STAGES-1];
    assign fin_id    = tag_id[STAGES-1];
    assign req_ready = grant;

    // Grant one eligible port; on a tie the port that did not win last goes.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (elig == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    // Per-port outstanding flag and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 2'b00;
            last <= 1'b1;
        end else begin
            busy <= (busy | grant) & ~rsp_hs;
            if (|grant) begin
                last <= grant[1];
            end
        end
    end

    // Operand registers hold when idle; tag pipe tracks the owner of each op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_src1 <= '0;
            mul_src2 <= '0;
            tag_vld  <= '0;
            tag_id   <= '0;
        end else begin
            tag_vld <= {tag_vld[STAGES-2:0], |grant};
            tag_id  <= {tag_id[STAGES-2:0], grant[1]};
            if (grant[0]) begin
                mul_src1 <= req_a0;
                mul_src2 <= req_b0;
            end else if (grant[1]) begin
                mul_src1 <= req_a1;
                mul_src2 <= req_b1;
            end
        end
    end

    // Capture the cell product into the owning port's response slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid   <= 2'b00;
            rsp_result0 <= '0;
            rsp_result1 <= '0;
        end else begin
            rsp_valid <= rsp_valid & ~rsp_hs;
            if (fin_vld) begin
                if (fin_id) begin
                    rsp_valid[1] <= 1'b1;
                    rsp_result1  <= mul_result;
                end else begin
                    rsp_valid[0] <= 1'b1;
                    rsp_result0  <= mul_result;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A capture must never land in a slot still holding a result.
    slot_free_a : assert property (
        @(posedge clk) disable iff (reset)
        fin_vld |-> !rsp_valid[fin_id]
    ) else $error("response slot overwrite on port %0d", fin_id);
`endif

endmodule

// File: tb/tb_nios_system_mult_arbiter.sv
// tb_nios_system_mult_arbiter: runs MUL_LATENCY=1 and =3 builds side by
// side on shared stimulus against a transaction-level reference model.
module tb_nios_system_mult_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_a0;
    logic [31:0] req_b0;
    logic [31:0] req_a1;
    logic [31:0] req_b1;
    logic [1:0]  rsp_ready;

    logic [1:0]  req_ready   [2];
    logic [1:0]  rsp_valid   [2];
    logic [31:0] rsp_result0 [2];
    logic [31:0] rsp_result1 [2];
    logic [31:0] mul_src1    [2];
    logic [31:0] mul_src2    [2];
    logic [31:0] mul_result  [2];
    logic [31:0] cpipe       [2][4];

    int lat [2] = '{1, 3};
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state, per instance k and port p
    bit          m_busy [2][2];
    bit          m_rv   [2][2];
    bit          m_inf  [2][2];
    int          m_cd   [2][2];
    logic [31:0] m_prod [2][2];
    logic [31:0] m_res  [2][2];
    bit          m_last [2];
    logic [31:0] m_s1   [2];
    logic [31:0] m_s2   [2];

    nios_system_mult_arbiter #(.MUL_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_result0(rsp_result0[0]), .rsp_result1(rsp_result1[0]),
        .rsp_ready(rsp_ready),
        .mul_src1(mul_src1[0]), .mul_src2(mul_src2[0]),
        .mul_result(mul_result[0])
    );

    nios_system_mult_arbiter #(.MUL_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_result0(rsp_result0[1]), .rsp_result1(rsp_result1[1]),
        .rsp_ready(rsp_ready),
        .mul_src1(mul_src1[1]), .mul_src2(mul_src2[1]),
        .mul_result(mul_result[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pipelined multiplier cell models, depth = latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cpipe[k][0] <= mul_src1[k] * mul_src2[k];
            for (int s = 1; s < 4; s++) cpipe[k][s] <= cpipe[k][s-1];
        end
    end
    assign mul_result[0] = cpipe[0][0];
    assign mul_result[1] = cpipe[1][2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_grant(input int k, input logic [1:0] rv);
        logic [1:0] e;
        int         other;
        for (int p = 0; p < 2; p++) e[p] = rv[p] && !m_busy[k][p];
        if (e == 2'b11) begin
            other = m_last[k] ? 0 : 1;
            return 2'(1 << other);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1;
            m_s1[k] = '0;
            m_s2[k] = '0;
            for (int p = 0; p < 2; p++) begin
                m_busy[k][p] = 0;
                m_rv[k][p] = 0;
                m_inf[k][p] = 0;
                m_cd[k][p] = 0;
                m_res[k][p] = '0;
                m_prod[k][p] = '0;
            end
        end
    endtask

    // entered and left at a falling edge; reset is released on exit
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #2;
        for (int k = 0; k < 2; k++) begin
            string s;
            s = $sformatf("L%0d", lat[k]);
            chk({"rst_req_ready_", s}, 32'(req_ready[k]), 32'h0);
            chk({"rst_rsp_valid_", s}, 32'(rsp_valid[k]), 32'h0);
            chk({"rst_result0_", s}, rsp_result0[k], 32'h0);
            chk({"rst_result1_", s}, rsp_result1[k], 32'h0);
            chk({"rst_src1_", s}, mul_src1[k], 32'h0);
            chk({"rst_src2_", s}, mul_src2[k], 32'h0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // one clock cycle: drive, compare, advance model across the edge
    task automatic step(input logic [1:0] rv, input logic [31:0] a0,
                        input logic [31:0] b0, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [1:0] rr);
        req_valid = rv;
        req_a0 = a0;
        req_b0 = b0;
        req_a1 = a1;
        req_b1 = b1;
        rsp_ready = rr;
        #2;
        for (int k = 0; k < 2; k++) begin
            logic [1:0] g;
            string      s;
            int         p;
            s = $sformatf("L%0d", lat[k]);
            g = exp_grant(k, rv);
            chk({"req_ready_", s}, 32'(req_ready[k]), 32'(g));
            chk({"rsp_valid_", s}, 32'(rsp_valid[k]), 32'({m_rv[k][1], m_rv[k][0]}));
            chk({"result0_", s}, rsp_result0[k], m_res[k][0]);
            chk({"result1_", s}, rsp_result1[k], m_res[k][1]);
            chk({"src1_", s}, mul_src1[k], m_s1[k]);
            chk({"src2_", s}, mul_src2[k], m_s2[k]);
            for (int q = 0; q < 2; q++) begin
                if (m_rv[k][q] && rr[q]) begin
                    m_rv[k][q] = 0;
                    m_busy[k][q] = 0;
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (m_inf[k][q]) begin
                    m_cd[k][q]--;
                    if (m_cd[k][q] == 0) begin
                        m_inf[k][q] = 0;
                        m_rv[k][q] = 1;
                        m_res[k][q] = m_prod[k][q];
                    end
                end
            end
            if (g != 2'b00) begin
                p = g[1] ? 1 : 0;
                m_busy[k][p] = 1;
                m_last[k] = g[1];
                m_inf[k][p] = 1;
                m_cd[k][p] = lat[k] + 1;
                m_s1[k] = p ? a1 : a0;
                m_s2[k] = p ? b1 : b0;
                m_prod[k][p] = m_s1[k] * m_s2[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [1:0] rr);
        repeat (n) step(2'b00, $urandom, $urandom, $urandom, $urandom, rr);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_a0 = '0;
        req_b0 = '0;
        req_a1 = '0;
        req_b1 = '0;
        rsp_ready = 2'b00;
        model_reset();
        @(negedge clk);
        do_reset();

        // single op on port 0
        step(2'b01, 32'd7, 32'd6, 32'd0, 32'd0, 2'b11);
        idle(6, 2'b11);
        for (int k = 0; k < 2; k++) chk("single_res", rsp_result0[k], 32'd42);

        // contention from reset, with wraparound on port 1
        do_reset();
        repeat (12) step(2'b11, 32'd3, 32'd5, 32'h10000, 32'h10000, 2'b11);
        idle(6, 2'b11);
        for (int k = 0; k < 2; k++) begin
            chk("cont_res0", rsp_result0[k], 32'd15);
            chk("cont_res1", rsp_result1[k], 32'd0);
        end

        // back-pressure on port 1 while port 0 keeps issuing
        do_reset();
        step(2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2, 2'b01);
        repeat (12) step(2'b11, $urandom, $urandom, 32'd5, 32'd5, 2'b01);
        for (int k = 0; k < 2; k++) chk("bp_hold", rsp_result1[k], 32'hFFFF_FFFE);
        repeat (4) step(2'b11, $urandom, $urandom, 32'd5, 32'd5, 2'b11);
        idle(6, 2'b11);
        for (int k = 0; k < 2; k++) chk("bp_res1", rsp_result1[k], 32'd25);

        // same-cycle response accept and new request on port 0
        do_reset();
        step(2'b01, 32'd11, 32'd13, 32'd0, 32'd0, 2'b00);
        repeat (5) step(2'b01, 32'd11, 32'd13, 32'd0, 32'd0, 2'b00);
        repeat (3) step(2'b01, 32'd100, 32'd3, 32'd0, 32'd0, 2'b01);
        idle(6, 2'b11);
        for (int k = 0; k < 2; k++) chk("same_res", rsp_result0[k], 32'd300);

        // reset one cycle after a port 1 grant
        do_reset();
        step(2'b10, 32'd0, 32'd0, 32'd77, 32'd77, 2'b11);
        do_reset();
        idle(6, 2'b11);
        step(2'b01, 32'd9, 32'd9, 32'd0, 32'd0, 2'b11);
        idle(6, 2'b11);
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_res0", rsp_result0[k], 32'd81);
            chk("post_rst_res1", rsp_result1[k], 32'd0);
        end

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step(2'($urandom_range(0, 3)), $urandom, $urandom,
                     $urandom, $urandom, 2'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_system_mult_arbiter.md
# nios_system_mult_arbiter

Two-port arbiter and sequencer that shares the CPU's pipelined 32-bit low-word multiplier cell between two requesters, for example the CPU custom-instruction path and an audio/video filter engine. It round-robins issue slots and drives registered operands into the cell. It tracks in-flight operations by tag and returns each product to the correct requester through a per-port response register with valid/ready handshake. It sits between the requesters and the multiplier cell inside the nios_system hierarchy.

## Interface
Parameters:
- MUL_LATENCY, default 1: cycles from operand change on mul_src1/mul_src2 to a valid mul_result. Legal range 1..4.

Ports:
- clk  in  1  single clock; all logic is clocked on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_a0, req_b0  in  32 each  port 0 operands.
- req_a1, req_b1  in  32 each  port 1 operands.
- req_ready  out  2  per-port request accept; combinational grant.
- rsp_valid  out  2  per-port response valid; registered.
- rsp_result0, rsp_result1  out  32 each  per-port product (low 32 bits of a*b); registered.
- rsp_ready  in  2  per-port response accept.
- mul_src1, mul_src2  out  32 each  registered operands to the multiplier cell.
- mul_result  in  32  multiplier cell product.

## Operation
- busy[i]:
  - set when port i's request handshake occurs;
  - cleared when port i's response handshake occurs (rsp_valid[i] & rsp_ready[i]).
  - Each port has at most one operation outstanding, counting both in-flight and buffered.
- Eligibility: elig[i] = req_valid[i] & ~busy[i].
- Arbitration is round-robin with a 1-bit pointer `last`:
  - if both ports are eligible, grant the port != last;
  - if only one port is eligible, grant it;
  - req_ready = one-hot grant, or 0 when nothing is eligible.
  - `last` updates to the granted port on every grant.
  - At most one grant per cycle.
- req_ready depends combinationally on req_valid and busy. Requesters must not make req_valid depend on req_ready.
- On grant of port g, at the clock edge:
  - mul_src1 <= req_a_g and mul_src2 <= req_b_g;
  - tag pipe stage 0 <= {valid=1, id=g}.
- With no grant, mul_src1/mul_src2 hold their values to avoid toggling, and tag stage 0 loads valid=0.
- Tag pipe has MUL_LATENCY+1 stages and shifts every cycle. When the final stage is valid with id=k:
  - rsp_result_k <= mul_result;
  - rsp_valid[k] <= 1.
- The response slot is guaranteed free by the busy rule. A capture into an occupied slot is a design error; flag it with a simulation-only assertion.
- rsp_valid[k] clears on the response handshake.
- rsp_result_k holds until the next capture.
- Arithmetic: unsigned modulo-2^32. The product is taken from the cell as-is; no sign or width adjustment.

## Timing
- Reset values: req_ready=0 while reset is high, rsp_valid=0, rsp_result0/1=0, mul_src1/2=0, busy=0, tag pipe valid=0, last=1 (so port 0 wins the first tie).
- Latency: request handshake in cycle t leads to rsp_valid high from cycle t+2+MUL_LATENCY (t+3 at default).
- Throughput:
  - alternating ports can issue one op per cycle;
  - a single port, with rsp_ready tied high, issues one op every 3+MUL_LATENCY cycles.
- Response accept and new request on the same port in the same cycle: busy clears at that edge, the port is not granted in that cycle, and it is granted no earlier than the next cycle. There is no same-cycle bypass.
- Response capture and response handshake on the same port in the same cycle cannot occur, because of the busy rule.
- Reset mid-operation: all in-flight tags are discarded, no response is produced for them, and busy, rsp_valid and the pointer return to reset values. The block accepts new requests on the first cycle after reset deasserts.
- rsp_valid, once high, stays high with stable rsp_result until rsp_ready is sampled high.

## Test plan
- Single op, port 0: a=7, b=6 with rsp_ready=1 → req_ready[0]=1 in the request cycle, mul_src1=7 one cycle later, rsp_valid[0]=1 with rsp_result0=42 exactly 3 cycles after the handshake, and no activity on port 1.
- Contention:
  - both ports valid continuously, port0 a=3, b=5 and port1 a=0x10000, b=0x10000;
  - the first grant goes to port 0, the next to port 1, and grants alternate while both are eligible;
  - results are 15 and 0 (wraparound), each on the correct port.
- Back-pressure: hold rsp_ready[1]=0 for 10 cycles after a port 1 op (a=0xFFFFFFFF, b=2) → rsp_result1=0xFFFFFFFE stays stable, req_ready[1] stays 0 throughout while port 0 keeps issuing, and port 1 is re-granted the cycle after rsp_ready[1] rises.
- Same-cycle accept and request on port 0 → no grant in that cycle, grant in the next cycle, and the second result is correct.
- Reset asserted one cycle after a port 1 grant → rsp_valid stays 0 and all outputs are at reset values; after deassertion, a fresh op a=9, b=9 returns 81.
- MUL_LATENCY=3 build: repeat the single-op and contention scenarios → response appears 5 cycles after the handshake and tags stay aligned with their products.
